i2c_eeprom_seq: RTL and testbench
=================================

Name: i2c_eeprom_seq

Overview:
Parametrised EEPROM test sequencer driving the request/ack port of i2c_master_top. It is the successor to the single-byte key-driven EEPROM test. It sweeps a programmable address range in one of three modes: read-only dump, write-only fill, or write-then-verify. Per-run status (pass, error count, first failing address) goes to LEDs or an ILA.

Parameters:
DEV_ADDR, 8'ha0, 8-bit I2C device address (write form, LSB 0).
ADDR_2BYTE, 0, 1 = 16-bit register addressing; 0 = 8-bit, reg address truncated to [7:0].
NUM_BYTES, 16, bytes per run, 1..65536.
BASE_ADDR, 16'h0000, first register address.
POWERUP_CYCLES, 12_500_000, cycles held in S_POWERUP after reset (250 ms at 50 MHz).
WR_CYCLES, 250_000, tWR wait after each write ack (5 ms at 50 MHz).

Ports:
sys_clk  in  1  system clock
rst_n  in  1  asynchronous reset, active low
start  in  1  single-cycle run request; accepted only in S_IDLE
mode  in  2  0 = read dump, 1 = write fill, 2 = write+verify, 3 = treated as 0; sampled with start
seed  in  8  pattern seed, sampled with start
i2c_read_req  out  1  read request to master
i2c_read_req_ack  in  1  read complete; i2c_read_data valid this cycle
i2c_write_req  out  1  write request to master
i2c_write_req_ack  in  1  write complete
i2c_error  in  1  master error flag; sampled together with either ack
i2c_slave_dev_addr  out  8  constant DEV_ADDR
i2c_slave_reg_addr  out  16  current register address
i2c_write_data  out  8  current write byte
i2c_read_data  in  8  read byte
i2c_addr_2byte  out  1  constant ADDR_2BYTE
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse at end of run
pass  out  1  valid from done until next start: err_count==0
err_count  out  16  mismatches plus master errors in current run, saturating at 16'hffff
first_fail_addr  out  16  reg address of first error in run; 16'hffff if none
read_data  out  8  last byte read

Behaviour:
- Reset values: all outputs 0, except first_fail_addr = 16'hffff; i2c_slave_dev_addr = DEV_ADDR and i2c_addr_2byte = ADDR_2BYTE at all times; state = S_POWERUP; counters 0.
- States: S_POWERUP, S_IDLE, S_WRITE, S_WR_WAIT, S_READ, S_DONE.
- S_POWERUP:
  - counts to POWERUP_CYCLES-1, then moves to S_IDLE.
  - start is ignored here.
- S_IDLE, on start:
  - latch mode and seed; idx = 0; err_count = 0; first_fail_addr = ffff; pass = 0; busy = 1.
  - mode 1/2 go to S_WRITE; mode 0/3 go to S_READ.
- Address and pattern rules:
  - reg_addr = BASE_ADDR + idx, mod 2^16; when ADDR_2BYTE=0, bits [15:8] are forced to 0 (wraps at 256).
  - pattern = seed + idx[7:0] + {idx[15:8]}, mod 256.
- Request handshake:
  - the request is held high with reg_addr/write_data stable until its ack.
  - the request drops the cycle after the ack.
  - at most one request is asserted at a time.
  - ack without a pending request is ignored.
- S_WRITE:
  - assert i2c_write_req with write_data = pattern.
  - on ack: if i2c_error, count an error; then go to S_WR_WAIT.
- S_WR_WAIT:
  - wait WR_CYCLES cycles.
  - then idx++; if idx == NUM_BYTES: mode 1 goes to S_DONE; mode 2 sets idx = 0 and goes to S_READ. Otherwise go to S_WRITE.
- S_READ:
  - assert i2c_read_req.
  - on ack: read_data <= i2c_read_data.
  - errors: count if i2c_error; in mode 2 also count if i2c_read_data != pattern. A single read counts at most 1 error.
  - then idx++ and re-request, or go to S_DONE when idx == NUM_BYTES.
  - mode 0 never counts mismatches.
- Error bookkeeping: on the first counted error, first_fail_addr <= current reg_addr.
- S_DONE:
  - one cycle: done = 1, busy = 0, pass = (err_count == 0).
  - then S_IDLE.
- Simultaneous events:
  - start while busy or during S_DONE is ignored.
  - both acks high in one cycle: only the ack matching the pending request is honoured.
- Reset mid-run:
  - requests drop immediately and the run is aborted.
  - the block re-enters S_POWERUP.
- Index counter is 17 bits so NUM_BYTES = 65536 terminates.

Test Plan:
1. POWERUP_CYCLES=10: pulse start at cycle 5 -> ignored; busy stays 0; pulse start after cycle 10 -> busy 1 on the next cycle.
2. Mode 2, NUM_BYTES=4, BASE=16'h10, seed=8'h55, WR_CYCLES=20, ideal EEPROM model -> 4 writes to 10..13 with data 55,56,57,58, each followed by ≥20 idle cycles, then 4 reads; done pulse with pass=1, err_count=0, first_fail_addr=ffff, read_data=58.
3. Same as 2, but the model corrupts addr 12 (returns 00) -> pass=0, err_count=1, first_fail_addr=0012.
4. ADDR_2BYTE=0, BASE=16'h00fe, NUM_BYTES=4, mode 1 -> reg_addr sequence 00fe, 00ff, 0000, 0001; i2c_addr_2byte=0; read_req never asserted.
5. Mode 0, model asserts i2c_error with the 2nd read ack -> err_count=1, first_fail_addr=BASE+1, all 4 reads still issued.
6. Assert rst_n low while write_req is pending -> write_req=0, busy=0, first_fail_addr=ffff immediately; state returns through S_POWERUP; a delayed ack during S_POWERUP is ignored.

Source files
------------

// File: rtl/i2c_eeprom_seq.sv
`default_nettype none
// ============================================================================
// Module   : i2c_eeprom_seq
// Brief    : EEPROM test sequencer for the i2c_master_top request/ack port.
//            Sweeps a register address range as a read dump, a write fill,
//            or a write-then-verify pass, and reports pass / error count /
//            first failing address for the run.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_eeprom_seq #(
  parameter logic [7:0]  DEV_ADDR       = 8'ha0,
  parameter int          ADDR_2BYTE     = 0,
  parameter int          NUM_BYTES      = 16,
  parameter logic [15:0] BASE_ADDR      = 16'h0000,
  parameter int          POWERUP_CYCLES = 12_500_000,
  parameter int          WR_CYCLES      = 250_000
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  mode,
  input  logic [7:0]  seed,
  output logic        i2c_read_req,
  input  logic        i2c_read_req_ack,
  output logic        i2c_write_req,
  input  logic        i2c_write_req_ack,
  input  logic        i2c_error,
  output logic [7:0]  i2c_slave_dev_addr,
  output logic [15:0] i2c_slave_reg_addr,
  output logic [7:0]  i2c_write_data,
  input  logic [7:0]  i2c_read_data,
  output logic        i2c_addr_2byte,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [15:0] first_fail_addr,
  output logic [7:0]  read_data
);

  // Sequencer states
  localparam logic [2:0] S_POWERUP = 3'd0;
  localparam logic [2:0] S_IDLE    = 3'd1;
  localparam logic [2:0] S_WRITE   = 3'd2;
  localparam logic [2:0] S_WR_WAIT = 3'd3;
  localparam logic [2:0] S_READ    = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  // Run modes as stored internally (mode 3 is folded into the read dump)
  localparam logic [1:0] c_mode_dump   = 2'd0;
  localparam logic [1:0] c_mode_fill   = 2'd1;
  localparam logic [1:0] c_mode_verify = 2'd2;

  // Terminal counts for the shared cycle timer; zero-length waits take one cycle
  localparam logic [31:0] c_pwr_last = (POWERUP_CYCLES > 1) ? 32'(POWERUP_CYCLES - 1) : 32'd0;
  localparam logic [31:0] c_wr_last  = (WR_CYCLES > 1)      ? 32'(WR_CYCLES - 1)      : 32'd0;
  // Index is one bit wider than the address so a full 64K sweep can terminate
  localparam logic [16:0] c_num_bytes = 17'(NUM_BYTES);

  // Register address for a given byte index; 8-bit addressing wraps at 256
  function automatic logic [15:0] addr_of(input logic [15:0] idx);
    logic [15:0] a;
    a = BASE_ADDR + idx;
    if (ADDR_2BYTE == 0) begin
      a[15:8] = 8'h00;
    end
    return a;
  endfunction

  // Test pattern: seed plus both index bytes, modulo 256
  function automatic logic [7:0] pattern_of(input logic [7:0] s, input logic [15:0] idx);
    return s + idx[7:0] + idx[15:8];
  endfunction

  logic [2:0]  state_q,   state_d;
  logic [31:0] cnt_q,     cnt_d;
  logic [16:0] idx_q,     idx_d;
  logic [1:0]  mode_q,    mode_d;
  logic [7:0]  seed_q,    seed_d;
  logic [15:0] err_q,     err_d;
  logic [15:0] ffa_q,     ffa_d;
  logic        pass_q,    pass_d;
  logic        busy_q,    busy_d;
  logic        done_q,    done_d;
  logic [7:0]  rdata_q,   rdata_d;
  logic        wreq_q,    wreq_d;
  logic        rreq_q,    rreq_d;
  logic [15:0] addr_q,    addr_d;
  logic [7:0]  wdata_q,   wdata_d;

  logic [16:0] w_idx_inc;
  logic        w_load;
  logic        w_err;
  logic        w_finish;

  assign w_idx_inc = idx_q + 17'd1;

  // Next-state and datapath update for the sequencer
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    mode_d   = mode_q;
    seed_d   = seed_q;
    err_d    = err_q;
    ffa_d    = ffa_q;
    pass_d   = pass_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    rdata_d  = rdata_q;
    wreq_d   = wreq_q;
    rreq_d   = rreq_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    w_load   = 1'b0;
    w_err    = 1'b0;
    w_finish = 1'b0;

    case (state_q)
      S_POWERUP: begin
        if (cnt_q == c_pwr_last) begin
          cnt_d   = 32'd0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      S_IDLE: begin
        if (start) begin
          mode_d = (mode == 2'd3) ? c_mode_dump : mode;
          seed_d = seed;
          idx_d  = 17'd0;
          w_load = 1'b1;
          err_d  = 16'h0000;
          ffa_d  = 16'hffff;
          pass_d = 1'b0;
          busy_d = 1'b1;
          if ((mode == c_mode_fill) || (mode == c_mode_verify)) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_READ;
          end
        end
      end

      S_WRITE: begin
        // Request rises one cycle after entry and drops the cycle after its ack
        if (!wreq_q) begin
          wreq_d = 1'b1;
        end else if (i2c_write_req_ack) begin
          wreq_d  = 1'b0;
          w_err   = i2c_error;
          cnt_d   = 32'd0;
          state_d = S_WR_WAIT;
        end
      end

      S_WR_WAIT: begin
        if (cnt_q == c_wr_last) begin
          cnt_d = 32'd0;
          if (w_idx_inc == c_num_bytes) begin
            if (mode_q == c_mode_verify) begin
              idx_d   = 17'd0;
              w_load  = 1'b1;
              state_d = S_READ;
            end else begin
              w_finish = 1'b1;
            end
          end else begin
            idx_d   = w_idx_inc;
            w_load  = 1'b1;
            state_d = S_WRITE;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      S_READ: begin
        if (!rreq_q) begin
          rreq_d = 1'b1;
        end else if (i2c_read_req_ack) begin
          rreq_d  = 1'b0;
          rdata_d = i2c_read_data;
          // A master error and a data mismatch on the same byte count once;
          // write_data still holds this index's pattern during the read pass.
          w_err = i2c_error |
                  ((mode_q == c_mode_verify) && (i2c_read_data != wdata_q));
          if (w_idx_inc == c_num_bytes) begin
            w_finish = 1'b1;
          end else begin
            idx_d  = w_idx_inc;
            w_load = 1'b1;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        wreq_d  = 1'b0;
        rreq_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    // Saturating error count; the first error of a run records its address
    if (w_err) begin
      if (err_q != 16'hffff) begin
        err_d = err_q + 16'd1;
      end
      if (err_q == 16'h0000) begin
        ffa_d = addr_q;
      end
    end

    // Address and pattern follow the index whenever it is (re)loaded
    if (w_load) begin
      addr_d  = addr_of(idx_d[15:0]);
      wdata_d = pattern_of(seed_d, idx_d[15:0]);
    end

    // End of run: done pulses during S_DONE with the final verdict
    if (w_finish) begin
      idx_d   = w_idx_inc;
      state_d = S_DONE;
      done_d  = 1'b1;
      busy_d  = 1'b0;
      pass_d  = (err_d == 16'h0000);
    end
  end

  // State and datapath registers; reset aborts any run and drops requests
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_POWERUP;
      cnt_q   <= 32'd0;
      idx_q   <= 17'd0;
      mode_q  <= 2'd0;
      seed_q  <= 8'h00;
      err_q   <= 16'h0000;
      ffa_q   <= 16'hffff;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= 8'h00;
      wreq_q  <= 1'b0;
      rreq_q  <= 1'b0;
      addr_q  <= 16'h0000;
      wdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      seed_q  <= seed_d;
      err_q   <= err_d;
      ffa_q   <= ffa_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      wreq_q  <= wreq_d;
      rreq_q  <= rreq_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign i2c_slave_dev_addr = DEV_ADDR;
  assign i2c_addr_2byte     = (ADDR_2BYTE != 0);
  assign i2c_write_req      = wreq_q;
  assign i2c_read_req       = rreq_q;
  assign i2c_slave_reg_addr = addr_q;
  assign i2c_write_data     = wdata_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign pass               = pass_q;
  assign err_count          = err_q;
  assign first_fail_addr    = ffa_q;
  assign read_data          = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_eeprom_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_eeprom_seq
// Brief    : Self-checking bench for i2c_eeprom_seq with a small EEPROM
//            responder model. Instance A: 16-bit addressing from 0x0010;
//            instance B: 8-bit addressing from 0x00fe.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_eeprom_seq;

  localparam int LAT = 3;

  logic sys_clk = 1'b0;
  logic rst_n   = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic        start_a, start_b;
  logic [1:0]  mode;
  logic [7:0]  seed;
  logic        man_wack, man_rack, man_err, model_en;

  logic        wr_req [2];
  logic        rd_req [2];
  logic        wack   [2];
  logic        rack   [2];
  logic        err    [2];
  logic [7:0]  dev    [2];
  logic [15:0] raddr  [2];
  logic [7:0]  wdata  [2];
  logic [7:0]  rdata  [2];
  logic        a2b    [2];
  logic        busy   [2];
  logic        done   [2];
  logic        pass   [2];
  logic [15:0] errc   [2];
  logic [15:0] ffa    [2];
  logic [7:0]  rdo    [2];

  i2c_eeprom_seq #(
    .DEV_ADDR(8'ha0), .ADDR_2BYTE(1), .NUM_BYTES(4), .BASE_ADDR(16'h0010),
    .POWERUP_CYCLES(10), .WR_CYCLES(20)
  ) dut_a (
    .sys_clk(sys_clk), .rst_n(rst_n), .start(start_a), .mode(mode), .seed(seed),
    .i2c_read_req(rd_req[0]), .i2c_read_req_ack(rack[0] | man_rack),
    .i2c_write_req(wr_req[0]), .i2c_write_req_ack(wack[0] | man_wack),
    .i2c_error(err[0] | man_err), .i2c_slave_dev_addr(dev[0]),
    .i2c_slave_reg_addr(raddr[0]), .i2c_write_data(wdata[0]),
    .i2c_read_data(rdata[0]), .i2c_addr_2byte(a2b[0]), .busy(busy[0]),
    .done(done[0]), .pass(pass[0]), .err_count(errc[0]),
    .first_fail_addr(ffa[0]), .read_data(rdo[0])
  );

  i2c_eeprom_seq #(
    .DEV_ADDR(8'ha2), .ADDR_2BYTE(0), .NUM_BYTES(4), .BASE_ADDR(16'h00fe),
    .POWERUP_CYCLES(10), .WR_CYCLES(5)
  ) dut_b (
    .sys_clk(sys_clk), .rst_n(rst_n), .start(start_b), .mode(mode), .seed(seed),
    .i2c_read_req(rd_req[1]), .i2c_read_req_ack(rack[1]),
    .i2c_write_req(wr_req[1]), .i2c_write_req_ack(wack[1]),
    .i2c_error(err[1]), .i2c_slave_dev_addr(dev[1]),
    .i2c_slave_reg_addr(raddr[1]), .i2c_write_data(wdata[1]),
    .i2c_read_data(rdata[1]), .i2c_addr_2byte(a2b[1]), .busy(busy[1]),
    .done(done[1]), .pass(pass[1]), .err_count(errc[1]),
    .first_fail_addr(ffa[1]), .read_data(rdo[1])
  );

  // ---------------- EEPROM responder model (acks after LAT request cycles)
  int          cyc          = 0;
  int          both_hi      = 0;
  int          min_idle     = 1000000;
  int          cnt          [2] = '{0, 0};
  int          nwr_tot      [2] = '{0, 0};
  int          nrd_tot      [2] = '{0, 0};
  int          rd_seen      [2] = '{0, 0};
  int          last_ack_cyc [2] = '{0, 0};
  logic        ack_valid    [2] = '{1'b0, 1'b0};
  logic        prev_req     [2] = '{1'b0, 1'b0};
  logic [7:0]  mem    [2][256];
  logic [15:0] wlog_a [2][64];
  logic [7:0]  wlog_d [2][64];
  logic [15:0] rlog_a [2][64];

  // Per-run fault injection for instance A, written by the stimulus process
  int corrupt_addr, err_wr_n, err_rd_n, wr_base, rd_base;

  always @(negedge sys_clk) begin
    cyc = cyc + 1;
    for (int k = 0; k < 2; k++) begin
      if (wr_req[k] === 1'b1 && rd_req[k] === 1'b1) both_hi = both_hi + 1;
      if (rd_req[k] === 1'b1) rd_seen[k] = rd_seen[k] + 1;
      if ((wr_req[k] | rd_req[k]) === 1'b1 && !prev_req[k] && ack_valid[k]) begin
        if (k == 0 && (cyc - last_ack_cyc[k] - 1) < min_idle)
          min_idle = cyc - last_ack_cyc[k] - 1;
        ack_valid[k] = 1'b0;
      end
      prev_req[k] = ((wr_req[k] | rd_req[k]) === 1'b1);
      if (model_en !== 1'b1 || wack[k] === 1'b1 || rack[k] === 1'b1) begin
        wack[k] = 1'b0; rack[k] = 1'b0; err[k] = 1'b0; cnt[k] = 0;
      end else if (wr_req[k] === 1'b1) begin
        cnt[k] = cnt[k] + 1;
        if (cnt[k] == LAT) begin
          wack[k] = 1'b1;
          mem[k][raddr[k][7:0]] = wdata[k];
          wlog_a[k][nwr_tot[k] % 64] = raddr[k];
          wlog_d[k][nwr_tot[k] % 64] = wdata[k];
          nwr_tot[k] = nwr_tot[k] + 1;
          err[k] = (k == 0) && (nwr_tot[k] - wr_base == err_wr_n);
          last_ack_cyc[k] = cyc;
          ack_valid[k] = 1'b1;
        end
      end else if (rd_req[k] === 1'b1) begin
        cnt[k] = cnt[k] + 1;
        if (cnt[k] == LAT) begin
          rack[k] = 1'b1;
          rdata[k] = (k == 0 && int'(raddr[k]) == corrupt_addr) ? 8'h00 : mem[k][raddr[k][7:0]];
          rlog_a[k][nrd_tot[k] % 64] = raddr[k];
          nrd_tot[k] = nrd_tot[k] + 1;
          err[k] = (k == 0) && (nrd_tot[k] - rd_base == err_rd_n);
        end
      end
    end
  end

  // ---------------- checking helpers
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_done(input int k, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (done[k] === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge sys_clk);
    end
    checks = checks + 1;
    if (!ok) begin
      failures = failures + 1;
      $display("FAIL done_timeout inst=%0d actual=no_done required=done", k);
    end
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic [7:0]  seed;
    int          corrupt;
    int          err_wr;
    int          err_rd;
    logic        exp_pass;
    logic [15:0] exp_err;
    logic [15:0] exp_ffa;
    logic [7:0]  exp_rd;
    int          exp_nwr;
    int          exp_nrd;
  } vec_t;

  vec_t vecs [8];
  vec_t vec_post;

  // One complete run on instance A, checked against the vector's expectations
  task automatic run_vec(input vec_t v, input string tag);
    bit         ok;
    logic [7:0] ed;
    corrupt_addr = v.corrupt;
    err_wr_n     = v.err_wr;
    err_rd_n     = v.err_rd;
    wr_base      = nwr_tot[0];
    rd_base      = nrd_tot[0];
    mode         = v.mode;
    seed         = v.seed;
    start_a      = 1'b1;
    @(negedge sys_clk);
    start_a = 1'b0;
    chk($sformatf("%s_busy_on_start", tag), busy[0], 1);
    wait_done(0, ok);
    if (ok) begin
      chk($sformatf("%s_busy_at_done", tag), busy[0], 0);
      chk($sformatf("%s_pass", tag), pass[0], v.exp_pass);
      chk($sformatf("%s_err_count", tag), errc[0], v.exp_err);
      chk($sformatf("%s_first_fail", tag), ffa[0], v.exp_ffa);
      chk($sformatf("%s_read_data", tag), rdo[0], v.exp_rd);
      @(negedge sys_clk);
      chk($sformatf("%s_done_one_cycle", tag), done[0], 0);
      chk($sformatf("%s_pass_held", tag), pass[0], v.exp_pass);
    end
    chk($sformatf("%s_num_writes", tag), nwr_tot[0] - wr_base, v.exp_nwr);
    chk($sformatf("%s_num_reads", tag), nrd_tot[0] - rd_base, v.exp_nrd);
    for (int i = 0; i < v.exp_nwr; i++) begin
      ed = v.seed + 8'(i);
      chk($sformatf("%s_wr%0d_addr", tag, i), wlog_a[0][(wr_base + i) % 64], 16'h0010 + 16'(i));
      chk($sformatf("%s_wr%0d_data", tag, i), wlog_d[0][(wr_base + i) % 64], ed);
    end
    for (int i = 0; i < v.exp_nrd; i++) begin
      chk($sformatf("%s_rd%0d_addr", tag, i), rlog_a[0][(rd_base + i) % 64], 16'h0010 + 16'(i));
    end
  endtask

  // ---------------- stimulus
  initial begin
    bit          ok;
    logic [15:0] exp_b [4];
    start_a = 1'b0; start_b = 1'b0; mode = 2'd0; seed = 8'h00;
    man_wack = 1'b0; man_rack = 1'b0; man_err = 1'b0; model_en = 1'b1;
    corrupt_addr = -1; err_wr_n = 0; err_rd_n = 0; wr_base = 0; rd_base = 0;

    //            mode   seed   corr   ewr erd pass err      ffa       rd    nwr nrd
    vecs[0] = '{2'd2, 8'h55, -1,    0,  0,  1'b1, 16'd0, 16'hffff, 8'h58, 4, 4};
    vecs[1] = '{2'd2, 8'h55, 'h12,  0,  0,  1'b0, 16'd1, 16'h0012, 8'h58, 4, 4};
    vecs[2] = '{2'd0, 8'h00, -1,    0,  2,  1'b0, 16'd1, 16'h0011, 8'h58, 0, 4};
    vecs[3] = '{2'd1, 8'hf0, -1,    3,  0,  1'b0, 16'd1, 16'h0012, 8'h58, 4, 0};
    vecs[4] = '{2'd3, 8'h00, -1,    0,  0,  1'b1, 16'd0, 16'hffff, 8'hf3, 0, 4};
    vecs[5] = '{2'd2, 8'hff, -1,    0,  0,  1'b1, 16'd0, 16'hffff, 8'h02, 4, 4};
    vecs[6] = '{2'd2, 8'h20, 'h10,  0,  1,  1'b0, 16'd1, 16'h0010, 8'h23, 4, 4};
    vecs[7] = '{2'd2, 8'h30, 'h11,  0,  4,  1'b0, 16'd2, 16'h0011, 8'h33, 4, 4};
    vec_post = '{2'd0, 8'h00, -1,   0,  0,  1'b1, 16'd0, 16'hffff, 8'h33, 0, 4};

    // Reset values on both instances
    repeat (3) @(negedge sys_clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst%0d_write_req", k), wr_req[k], 0);
      chk($sformatf("rst%0d_read_req", k), rd_req[k], 0);
      chk($sformatf("rst%0d_busy", k), busy[k], 0);
      chk($sformatf("rst%0d_done", k), done[k], 0);
      chk($sformatf("rst%0d_pass", k), pass[k], 0);
      chk($sformatf("rst%0d_err_count", k), errc[k], 0);
      chk($sformatf("rst%0d_first_fail", k), ffa[k], 16'hffff);
      chk($sformatf("rst%0d_read_data", k), rdo[k], 0);
      chk($sformatf("rst%0d_reg_addr", k), raddr[k], 0);
      chk($sformatf("rst%0d_write_data", k), wdata[k], 0);
    end
    chk("rst0_dev_addr", dev[0], 8'ha0);
    chk("rst1_dev_addr", dev[1], 8'ha2);
    chk("rst0_addr_2byte", a2b[0], 1);
    chk("rst1_addr_2byte", a2b[1], 0);
    rst_n = 1'b1;

    // Start during power-up is ignored; start after power-up is accepted
    repeat (4) @(negedge sys_clk);
    mode = 2'd1; start_a = 1'b1;
    @(negedge sys_clk);
    start_a = 1'b0;
    chk("powerup_start_ignored", busy[0], 0);
    repeat (6) @(negedge sys_clk);
    chk("powerup_still_idle", busy[0], 0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("v%0d", i));
    chk("write_wait_idle_ge_20", (min_idle >= 20) ? 32'd1 : 32'd0, 1);

    // 8-bit addressing wraps at 256 on instance B, fill mode never reads
    exp_b[0] = 16'h00fe; exp_b[1] = 16'h00ff; exp_b[2] = 16'h0000; exp_b[3] = 16'h0001;
    mode = 2'd1; seed = 8'h11; start_b = 1'b1;
    @(negedge sys_clk);
    start_b = 1'b0;
    chk("b_busy_on_start", busy[1], 1);
    wait_done(1, ok);
    if (ok) begin
      chk("b_pass", pass[1], 1);
      chk("b_err_count", errc[1], 0);
    end
    chk("b_num_writes", nwr_tot[1], 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("b_wr%0d_addr", i), wlog_a[1][i], exp_b[i]);
      chk($sformatf("b_wr%0d_data", i), wlog_d[1][i], 8'h11 + 8'(i));
    end
    chk("b_read_req_never", rd_seen[1], 0);
    chk("b_addr_2byte", a2b[1], 0);

    // Reset while a write request is pending
    mode = 2'd1; seed = 8'h00; start_a = 1'b1;
    @(negedge sys_clk);
    start_a = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (wr_req[0] === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge sys_clk);
    end
    chk("mid_run_write_req_seen", ok, 1);
    model_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_write_req", wr_req[0], 0);
    chk("mid_rst_busy", busy[0], 0);
    chk("mid_rst_first_fail", ffa[0], 16'hffff);
    chk("mid_rst_read_data", rdo[0], 0);
    @(negedge sys_clk);
    rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    man_wack = 1'b1; man_rack = 1'b1; man_err = 1'b1;
    @(negedge sys_clk);
    man_wack = 1'b0; man_rack = 1'b0; man_err = 1'b0;
    @(negedge sys_clk);
    chk("powerup_ack_busy", busy[0], 0);
    chk("powerup_ack_err_count", errc[0], 0);
    chk("powerup_ack_first_fail", ffa[0], 16'hffff);
    chk("powerup_ack_write_req", wr_req[0], 0);
    chk("powerup_ack_read_req", rd_req[0], 0);
    chk("powerup_ack_done", done[0], 0);
    repeat (10) @(negedge sys_clk);
    // Acks with no request pending in idle are ignored
    man_wack = 1'b1; man_rack = 1'b1; man_err = 1'b1;
    @(negedge sys_clk);
    man_wack = 1'b0; man_rack = 1'b0; man_err = 1'b0;
    @(negedge sys_clk);
    chk("idle_ack_err_count", errc[0], 0);
    chk("idle_ack_busy", busy[0], 0);
    model_en = 1'b1;
    run_vec(vec_post, "post_rst");

    chk("one_request_at_a_time", both_hi, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
